// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, the bubble instruction and the
// default reset PC, also used by the decode stage and the hazard unit.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    function automatic logic fetch_addr_bad(input logic [31:0] pc, input logic [31:0] limit);
        return (pc[1:0] != 2'b00) || (pc >= limit);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// Generic pipeline register with flush/hold/load controls (flush > hold > load);
// reused by later pipeline stages with the same stall/flush pattern.
module if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        valid_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    ifid_t reg_q, reg_d;

    always_comb begin
        reg_d = reg_q;
        if (flush_i) begin
            // Only the payload is cleared; the PC fields keep their last value.
            reg_d.instr = NOP_INSTR;
            reg_d.valid = 1'b0;
        end else if (hold_i) begin
            reg_d = reg_q;
        end else if (load_i) begin
            reg_d.instr    = instr_i;
            reg_d.pc       = pc_i;
            reg_d.pc_plus4 = pc_plus4_i;
            reg_d.valid    = valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_q.instr    <= NOP_INSTR;
            reg_q.pc       <= '0;
            reg_q.pc_plus4 <= 32'd4;
            reg_q.valid    <= 1'b0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign instr_o    = reg_q.instr;
    assign pc_o       = reg_q.pc;
    assign pc_plus4_o = reg_q.pc_plus4;
    assign valid_o    = reg_q.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: PC, IF/ID capture, stall/redirect/fault handling.
// Optional FETCH_COUNT/BUBBLE_COUNT outputs when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] IMEM_LIMIT = 32'd1024,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_INSTRUCTION,
    output logic [31:0] IFID_INSTRUCTION,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC_PLUS4,
    output logic        IFID_VALID,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] FETCH_COUNT,
    output logic [31:0] BUBBLE_COUNT,
`endif
    output logic        FETCH_FAULT
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  pc_plus4;
    logic         ifid_load, ifid_flush, ifid_hold;
    logic         bubble;

    assign pc_plus4     = pc_q + 32'd4;
    assign IMEM_ADDRESS = pc_q;
    assign FETCH_FAULT  = fault_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        bubble     = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                ifid_hold = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (REDIRECT) begin
                    ifid_flush = 1'b1;
                    pc_d       = REDIRECT_PC;
                    bubble     = 1'b1;
                end else if (STALL) begin
                    ifid_hold = 1'b1;
                    bubble    = 1'b1;
                end else if (fetch_addr_bad(pc_q, IMEM_LIMIT)) begin
                    // The faulting word is never captured: the register is flushed instead.
                    ifid_flush = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = ST_FAULT;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end
            end
            ST_FAULT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                ifid_flush = 1'b1;
                state_d    = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_register (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (ifid_load),
        .flush_i    (ifid_flush),
        .hold_i     (ifid_hold),
        .instr_i    (IMEM_INSTRUCTION),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .valid_i    (1'b1),
        .instr_o    (IFID_INSTRUCTION),
        .pc_o       (IFID_PC),
        .pc_plus4_o (IFID_PC_PLUS4),
        .valid_o    (IFID_VALID)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (ifid_load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign FETCH_COUNT  = fetch_cnt_q;
    assign BUBBLE_COUNT = bubble_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

endmodule
